// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue path: opcode and FUNC3 encodings,
// the operand/control bundle carried through the skid buffer, the buffer
// occupancy states and the writeback bypass helper.
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [31:0] in0;
    logic [31:0] in1;
    logic [2:0]  func3;
    logic        sub;
    logic [4:0]  rd;
    logic        illegal;
  } alu_issue_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // x0 always reads zero; otherwise a same-cycle writeback to the register
  // wins over the (stale) register-file read.
  function automatic logic [31:0] pick_operand(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (idx == 5'd0)
      return 32'd0;
    else if (wb_en && (wb_rd == idx))
      return wb_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode
// Combinational decode of one instruction into an alu_issue_t bundle.
// Ports:
//   instr     raw instruction word
//   pc_in     PC of instr (AUIPC operand 0)
//   rs1_data  register-file read of instr[19:15]
//   rs2_data  register-file read of instr[24:20]
//   wb_en/wb_rd/wb_data  same-cycle writeback used for bypass
//   issue     decoded operand/control bundle
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output alu_issue_t  issue
);

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  assign rs1_val = pick_operand(instr[19:15], rs1_data, wb_en, wb_rd, wb_data);
  assign rs2_val = pick_operand(instr[24:20], rs2_data, wb_en, wb_rd, wb_data);
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'b0};

  always_comb begin
    issue    = '0;
    issue.rd = instr[11:7];
    case (instr[6:0])
      OPC_OP: begin
        issue.in0   = rs1_val;
        issue.in1   = rs2_val;
        issue.func3 = instr[14:12];
        issue.sub   = instr[30];
      end
      OPC_OPIMM: begin
        issue.in0   = rs1_val;
        issue.in1   = imm_i;
        issue.func3 = instr[14:12];
        // instr[30] is an immediate bit for everything except SRAI, so only
        // the right-shift encoding may turn it into the arithmetic select.
        issue.sub   = (instr[14:12] == F3_SR) ? instr[30] : 1'b0;
      end
      OPC_LUI: begin
        issue.in1   = imm_u;
        issue.func3 = F3_ADD;
      end
      OPC_AUIPC: begin
        issue.in0   = pc_in;
        issue.in1   = imm_u;
        issue.func3 = F3_ADD;
      end
      default: begin
        issue.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Issue stage in front of the ALU: decodes OP/OP-IMM/LUI/AUIPC with
// writeback bypass and holds results in a 2-entry skid buffer.
// Ports:
//   clk, rst (async, active-high), flush (sync, drops all entries)
//   instr_valid/instr_ready  upstream handshake; ready depends on state only
//   instr, pc_in, rs1_data, rs2_data, wb_en, wb_rd, wb_data  decode inputs
//   out_valid/out_ready      downstream handshake on the head entry
//   in0, in1, func3, sub, rd, illegal  head entry fields (0 when invalid)
//   alu_en                   out_valid & !illegal
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] in0,
  output logic [XLEN-1:0] in1,
  output logic [2:0]      func3,
  output logic            sub,
  output logic            alu_en,
  output logic [4:0]      rd,
  output logic            illegal
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("alu_operand_stage supports XLEN=32 only");
  end
  if (DEPTH != 2) begin : g_bad_depth
    $error("alu_operand_stage supports DEPTH=2 only");
  end

  buf_state_t state_q;
  alu_issue_t head_q;
  alu_issue_t skid_q;
  alu_issue_t new_entry;
  logic       accept;
  logic       drain;

  alu_decode u_decode (
    .instr    (instr),
    .pc_in    (pc_in),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .issue    (new_entry)
  );

  assign instr_ready = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign accept      = instr_valid & instr_ready;
  assign drain       = out_valid & out_ready;

  // head_q is cleared whenever the buffer empties, so the outputs read
  // zero for an invalid head without extra gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q  <= new_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_q <= new_entry;
          end else if (accept) begin
            skid_q  <= new_entry;
            state_q <= FULL;
          end else if (drain) begin
            head_q  <= '0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            head_q  <= skid_q;
            skid_q  <= '0;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          head_q  <= '0;
          skid_q  <= '0;
        end
      endcase
    end
  end

  assign in0     = head_q.in0;
  assign in1     = head_q.in1;
  assign func3   = head_q.func3;
  assign sub     = head_q.sub;
  assign rd      = head_q.rd;
  assign illegal = head_q.illegal;
  assign alu_en  = out_valid & ~head_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
// Randomized and directed stimulus for alu_operand_stage, checked every
// cycle against a queue-based behavioural model, plus literal expectations
// for the hand-worked cases.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        s;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [2:0]  func3;
  logic        sub;
  logic        alu_en;
  logic [4:0]  rd;
  logic        illegal;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t model_q[$];

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_in       (pc_in),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in0         (in0),
    .in1         (in1),
    .func3       (func3),
    .sub         (sub),
    .alu_en      (alu_en),
    .rd          (rd),
    .illegal     (illegal)
  );

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rdi);
    return {imm, rs1, f3, rdi, 7'b0010011};
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_u(input logic [19:0] imm, input logic [4:0] rdi,
                                       input logic [6:0] op);
    return {imm, rdi, op};
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf,
                                          input logic we, input logic [4:0] wrd,
                                          input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wrd == idx) return wd;
    return rf;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic we, input logic [4:0] wrd,
                                      input logic [31:0] wd);
    exp_t e;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] v1;
    logic [31:0] v2;
    e     = '0;
    e.rd  = ins[11:7];
    imm_i = $signed(ins) >>> 20;
    imm_u = ins & 32'hFFFF_F000;
    v1    = operand(ins[19:15], r1, we, wrd, wd);
    v2    = operand(ins[24:20], r2, we, wrd, wd);
    case (ins[6:0])
      7'h33: begin e.a = v1; e.b = v2; e.f = ins[14:12]; e.s = ins[30]; end
      7'h13: begin
        e.a = v1; e.b = imm_i; e.f = ins[14:12];
        e.s = (ins[14:12] == 3'd5) && ins[30];
      end
      7'h37: begin e.b = imm_u; end
      7'h17: begin e.a = pc; e.b = imm_u; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every output against the model's view of the buffer.
  task automatic checkOutput();
    exp_t h;
    h = '0;
    if (model_q.size() > 0) h = model_q[0];
    chk("instr_ready", 32'(instr_ready), 32'(model_q.size() < 2));
    chk("out_valid",   32'(out_valid),   32'(model_q.size() > 0));
    chk("alu_en",      32'(alu_en),      32'((model_q.size() > 0) && !h.ill));
    chk("in0",         in0,              h.a);
    chk("in1",         in1,              h.b);
    chk("func3",       32'(func3),       32'(h.f));
    chk("sub",         32'(sub),         32'(h.s));
    chk("rd",          32'(rd),          32'(h.rd));
    chk("illegal",     32'(illegal),     32'(h.ill));
  endtask

  // Drives one cycle of inputs, advances the model for that edge, and
  // returns #1 after the edge with the outputs checked.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                               input logic ordy, input logic fl);
    int sz;
    instr_valid = v;
    instr       = ins;
    pc_in       = pc;
    rs1_data    = r1;
    rs2_data    = r2;
    wb_en       = we;
    wb_rd       = wrd;
    wb_data     = wd;
    out_ready   = ordy;
    flush       = fl;
    sz = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (sz > 0 && ordy) void'(model_q.pop_front());
      if (v && sz < 2) model_q.push_back(ref_decode(ins, pc, r1, r2, we, wrd, wd));
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, ordy, 1'b0);
  endtask

  initial begin
    logic [31:0] ins;
    logic        v;
    logic        ordy;
    logic        fl;
    rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0; pc_in = '0;
    rs1_data = '0; rs2_data = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    #12;
    checkOutput();
    rst = 1'b0;

    // ADDI x5,x1,-1
    applyStimulus(1'b1, mk_i(12'hFFF, 5'd1, 3'd0, 5'd5), 32'h0, 32'h10, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("addi_in0", in0, 32'h10);
    chk("addi_in1", in1, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(rd), 32'd5);
    chk("addi_alu_en", 32'(alu_en), 32'd1);
    chk("addi_sub", 32'(sub), 32'd0);

    // SRAI x3,x2,4
    applyStimulus(1'b1, mk_i({7'b0100000, 5'd4}, 5'd2, 3'd5, 5'd3), 32'h0, 32'h80, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("srai_sub", 32'(sub), 32'd1);
    chk("srai_shamt", 32'(in1[4:0]), 32'd4);

    // SUB x3,x1,x2
    applyStimulus(1'b1, mk_r(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'h7, 32'h3,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("sub_sub", 32'(sub), 32'd1);
    chk("sub_func3", 32'(func3), 32'd0);
    chk("sub_in1", in1, 32'h3);

    // ADDI imm=0x400 must not subtract
    applyStimulus(1'b1, mk_i(12'h400, 5'd1, 3'd0, 5'd5), 32'h0, 32'h1, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("addi400_sub", 32'(sub), 32'd0);
    chk("addi400_in1", in1, 32'h400);

    // Bypass: ADD x4,x1,x0
    applyStimulus(1'b1, mk_r(7'd0, 5'd0, 5'd1, 3'd0, 5'd4), 32'h0, 32'h1, 32'h55,
                  1'b1, 5'd1, 32'hDEAD, 1'b1, 1'b0);
    chk("bypass_in0", in0, 32'hDEAD);
    chk("bypass_in1", in1, 32'h0);
    applyStimulus(1'b1, mk_r(7'd0, 5'd0, 5'd1, 3'd0, 5'd4), 32'h0, 32'h1, 32'h55,
                  1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b0);
    chk("nobypass_in0", in0, 32'h1);

    // LUI, AUIPC, load
    applyStimulus(1'b1, mk_u(20'h12345, 5'd1, 7'b0110111), 32'h0, 32'h9, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("lui_in1", in1, 32'h1234_5000);
    chk("lui_in0", in0, 32'h0);
    applyStimulus(1'b1, mk_u(20'h00001, 5'd2, 7'b0010111), 32'h100, 32'h9, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("auipc_in0", in0, 32'h100);
    chk("auipc_in1", in1, 32'h1000);
    applyStimulus(1'b1, {12'h004, 5'd1, 3'd2, 5'd6, 7'b0000011}, 32'h0, 32'h9, 32'h0,
                  1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("load_illegal", 32'(illegal), 32'd1);
    chk("load_alu_en", 32'(alu_en), 32'd0);
    chk("load_out_valid", 32'(out_valid), 32'd1);
    chk("load_rd", 32'(rd), 32'd6);
    idle(1'b1);

    // Backpressure: A, B accepted, C held upstream, then in-order drain
    applyStimulus(1'b1, mk_i(12'd1, 5'd0, 3'd0, 5'd10), 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_i(12'd2, 5'd0, 3'd0, 5'd11), 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b0);
    chk("full_ready", 32'(instr_ready), 32'd0);
    chk("full_head_rd", 32'(rd), 32'd10);
    applyStimulus(1'b1, mk_i(12'd3, 5'd0, 3'd0, 5'd12), 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b0);
    chk("held_head_rd", 32'(rd), 32'd10);
    applyStimulus(1'b1, mk_i(12'd3, 5'd0, 3'd0, 5'd12), 0, 0, 0, 1'b0, 5'd0, 0, 1'b1, 1'b0);
    chk("drain_b_rd", 32'(rd), 32'd11);
    chk("drain_b_in1", in1, 32'd2);
    applyStimulus(1'b1, mk_i(12'd3, 5'd0, 3'd0, 5'd12), 0, 0, 0, 1'b0, 5'd0, 0, 1'b1, 1'b0);
    chk("drain_c_rd", 32'(rd), 32'd12);
    idle(1'b1);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Flush in FULL and in ONE with an accept attempt
    applyStimulus(1'b1, mk_i(12'd7, 5'd0, 3'd0, 5'd1), 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_i(12'd8, 5'd0, 3'd0, 5'd2), 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_i(12'd9, 5'd0, 3'd0, 5'd3), 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b1);
    chk("flush_full_valid", 32'(out_valid), 32'd0);
    chk("flush_full_ready", 32'(instr_ready), 32'd1);
    applyStimulus(1'b1, mk_i(12'd7, 5'd0, 3'd0, 5'd1), 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_i(12'd9, 5'd0, 3'd0, 5'd3), 0, 0, 0, 1'b0, 5'd0, 0, 1'b1, 1'b1);
    chk("flush_one_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges
    applyStimulus(1'b1, {25'h1ABCDEF, 7'b1111111}, 0, 0, 0, 1'b0, 5'd0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_r(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3), 0, 32'h5, 32'h6,
                  1'b0, 5'd0, 0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    model_q.delete();
    checkOutput();
    chk("async_rst_illegal", 32'(illegal), 32'd0);
    #1;
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: ins[6:0] = 7'b0110011;
        1: ins[6:0] = 7'b0010011;
        2: ins[6:0] = 7'b0110111;
        3: ins[6:0] = 7'b0010111;
        4: ins[6:0] = 7'b0000011;
        default: ;
      endcase
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 29) == 0);
      applyStimulus(v, ins, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), $urandom, ordy, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
